// File: rtl/reg_wr_arbiter.sv
// reg_wr_arbiter: zero-fills x1..x(NREG-1) after reset, then round-robin arbitrates
// the register file write port between requesters A and B.
module reg_wr_arbiter #(
    parameter int NREG = 32,
    parameter int AW   = 5,
    parameter int DW   = 32
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          A_VALID,
    input  logic [AW-1:0] A_RD,
    input  logic [DW-1:0] A_DATA,
    output logic          A_READY,
    input  logic          B_VALID,
    input  logic [AW-1:0] B_RD,
    input  logic [DW-1:0] B_DATA,
    output logic          B_READY,
    output logic          WR,
    output logic [AW-1:0] RD,
    output logic [DW-1:0] DIN,
    output logic          BUSY
);
    typedef enum logic {INIT, RUN} state_t;

    state_t        state_q, state_d;
    logic [AW-1:0] cnt_q, cnt_d;
    logic          last_b_q, last_b_d;
    logic          wr_q, wr_d;
    logic [AW-1:0] rd_q, rd_d;
    logic [DW-1:0] din_q, din_d;
    logic          run, xfer;
    logic [AW-1:0] sel_rd;
    logic [DW-1:0] sel_data;

    // On contention the requester that did not win last time gets the port
    assign run      = state_q == RUN;
    assign A_READY  = run && A_VALID && (!B_VALID || last_b_q);
    assign B_READY  = run && B_VALID && (!A_VALID || !last_b_q);
    assign xfer     = A_READY || B_READY;
    assign sel_rd   = A_READY ? A_RD : B_RD;
    assign sel_data = A_READY ? A_DATA : B_DATA;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        last_b_d = last_b_q;
        wr_d     = 1'b0;
        rd_d     = rd_q;
        din_d    = din_q;
        if (state_q == INIT) begin
            wr_d    = 1'b1;
            rd_d    = cnt_q;
            din_d   = '0;
            cnt_d   = cnt_q + AW'(1);
            state_d = (cnt_q == AW'(NREG - 1)) ? RUN : INIT;
        end else if (xfer) begin
            wr_d     = sel_rd != '0;
            rd_d     = sel_rd;
            din_d    = sel_data;
            last_b_d = B_READY;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q  <= INIT;
            cnt_q    <= AW'(1);
            last_b_q <= 1'b1;
            wr_q     <= 1'b0;
            rd_q     <= '0;
            din_q    <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            last_b_q <= last_b_d;
            wr_q     <= wr_d;
            rd_q     <= rd_d;
            din_q    <= din_d;
        end
    end

    assign WR   = wr_q;
    assign RD   = rd_q;
    assign DIN  = din_q;
    assign BUSY = state_q == INIT;
endmodule

// File: tb/tb_reg_wr_arbiter.sv
// tb_reg_wr_arbiter: directed vector table plus hand-written init and reset sequences.
module tb_reg_wr_arbiter;
    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        A_VALID = 1'b1, B_VALID = 1'b1;
    logic [4:0]  A_RD = 5'd3, B_RD = 5'd4;
    logic [31:0] A_DATA = 32'h0, B_DATA = 32'h0;
    logic        A_READY, B_READY, WR, BUSY;
    logic [4:0]  RD;
    logic [31:0] DIN;
    int          checks = 0, errors = 0;
    logic [31:0] x7 = 32'hFFFF_FFFF;
    logic        x0_hit = 1'b0;

    reg_wr_arbiter dut (
        .CLK(CLK), .RST(RST),
        .A_VALID(A_VALID), .A_RD(A_RD), .A_DATA(A_DATA), .A_READY(A_READY),
        .B_VALID(B_VALID), .B_RD(B_RD), .B_DATA(B_DATA), .B_READY(B_READY),
        .WR(WR), .RD(RD), .DIN(DIN), .BUSY(BUSY)
    );

    always #5 CLK = ~CLK;

    // Tiny file model watching x0 and x7 through the write port
    always @(posedge CLK) begin
        if (WR && RD == 5'd7) x7 <= DIN;
        if (WR && RD == 5'd0) x0_hit <= 1'b1;
    end

    typedef struct {
        logic        av;
        logic [4:0]  ard;
        logic [31:0] adat;
        logic        bv;
        logic [4:0]  brd;
        logic [31:0] bdat;
        logic        ear;
        logic        ebr;
        logic        ewr;
        logic [4:0]  erd;
        logic [31:0] edin;
    } vec_t;

    vec_t vec [11];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%h want=%h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    initial begin
        vec[0]  = '{1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'h0,       1'b1, 1'b0, 1'b1, 5'd5, 32'hDEADBEEF};
        vec[1]  = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,       1'b0, 1'b0, 1'b0, 5'd5, 32'hDEADBEEF};
        vec[2]  = '{1'b0, 5'd0, 32'h0,        1'b1, 5'd9, 32'h99,      1'b0, 1'b1, 1'b1, 5'd9, 32'h99};
        vec[3]  = '{1'b1, 5'd3, 32'hAAAA0003, 1'b1, 5'd4, 32'hBBBB0004, 1'b1, 1'b0, 1'b1, 5'd3, 32'hAAAA0003};
        vec[4]  = '{1'b1, 5'd3, 32'hAAAA0003, 1'b1, 5'd4, 32'hBBBB0004, 1'b0, 1'b1, 1'b1, 5'd4, 32'hBBBB0004};
        vec[5]  = '{1'b1, 5'd3, 32'hAAAA0013, 1'b1, 5'd4, 32'hBBBB0014, 1'b1, 1'b0, 1'b1, 5'd3, 32'hAAAA0013};
        vec[6]  = '{1'b1, 5'd3, 32'hAAAA0023, 1'b1, 5'd4, 32'hBBBB0014, 1'b0, 1'b1, 1'b1, 5'd4, 32'hBBBB0014};
        vec[7]  = '{1'b0, 5'd0, 32'h0,        1'b1, 5'd0, 32'h1234,    1'b0, 1'b1, 1'b0, 5'd0, 32'h1234};
        vec[8]  = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,       1'b0, 1'b0, 1'b0, 5'd0, 32'h1234};
        vec[9]  = '{1'b1, 5'd7, 32'h1,        1'b1, 5'd7, 32'h2,       1'b1, 1'b0, 1'b1, 5'd7, 32'h1};
        vec[10] = '{1'b0, 5'd0, 32'h0,        1'b1, 5'd7, 32'h2,       1'b0, 1'b1, 1'b1, 5'd7, 32'h2};

        #2;
        chk("rst_wr", 32'(WR), 32'h0);
        chk("rst_rd", 32'(RD), 32'h0);
        chk("rst_din", DIN, 32'h0);
        chk("rst_busy", 32'(BUSY), 32'h1);
        chk("rst_ardy", 32'(A_READY), 32'h0);
        chk("rst_brdy", 32'(B_READY), 32'h0);
        step();
        RST = 1'b0;
        for (int i = 1; i <= 31; i++) begin
            chk($sformatf("init%0d_busy", i), 32'(BUSY), 32'h1);
            chk($sformatf("init%0d_rdy", i), 32'({A_READY, B_READY}), 32'h0);
            step();
            chk($sformatf("init%0d_wr", i), 32'(WR), 32'h1);
            chk($sformatf("init%0d_rd", i), 32'(RD), 32'(i));
            chk($sformatf("init%0d_din", i), DIN, 32'h0);
        end
        A_VALID = 1'b0;
        B_VALID = 1'b0;
        #1;
        chk("init_done_busy", 32'(BUSY), 32'h0);

        for (int i = 0; i < 11; i++) begin
            A_VALID = vec[i].av;  A_RD = vec[i].ard;  A_DATA = vec[i].adat;
            B_VALID = vec[i].bv;  B_RD = vec[i].brd;  B_DATA = vec[i].bdat;
            #1;
            chk($sformatf("v%0d_ardy", i), 32'(A_READY), 32'(vec[i].ear));
            chk($sformatf("v%0d_brdy", i), 32'(B_READY), 32'(vec[i].ebr));
            step();
            chk($sformatf("v%0d_wr", i), 32'(WR), 32'(vec[i].ewr));
            chk($sformatf("v%0d_rd", i), 32'(RD), 32'(vec[i].erd));
            chk($sformatf("v%0d_din", i), DIN, vec[i].edin);
        end
        B_VALID = 1'b0;
        step();
        chk("idle_after_same_wr", 32'(WR), 32'h0);
        chk("x7_final", x7, 32'h2);
        chk("x0_never_written", 32'(x0_hit), 32'h0);

        A_VALID = 1'b1; A_RD = 5'd6; A_DATA = 32'h66;
        #1;
        chk("mid_ardy_pre", 32'(A_READY), 32'h1);
        step();
        chk("mid_wr_pre", 32'(WR), 32'h1);
        #1;
        RST = 1'b1;
        #1;
        chk("mid_rst_wr", 32'(WR), 32'h0);
        chk("mid_rst_rdy", 32'({A_READY, B_READY}), 32'h0);
        chk("mid_rst_busy", 32'(BUSY), 32'h1);
        chk("mid_rst_rd", 32'(RD), 32'h0);
        step();
        chk("mid_rst_hold_wr", 32'(WR), 32'h0);
        RST = 1'b0;
        step();
        chk("restart_wr", 32'(WR), 32'h1);
        chk("restart_rd", 32'(RD), 32'h1);
        chk("restart_din", DIN, 32'h0);
        chk("restart_rdy", 32'({A_READY, B_READY}), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/reg_wr_arbiter.md
# reg_wr_arbiter

Write-port controller for the CPU's 32×32 register file. After reset it sequences a zero-fill of registers x1–x31 through the file's single write port. It then arbitrates that port between two write-back requesters, each using a valid/ready handshake:
- A: core write-back (ALU/load result).
- B: auxiliary writer (debug/multi-cycle unit).

Its registered outputs drive the register file's WR, RD and DIN inputs directly.

## Interface
Parameters:
- NREG, 32, number of architectural registers (power of two; x0 hardwired zero)
- AW, 5, register index width (log2 NREG)
- DW, 32, data width

Ports:
- CLK  in  1  single clock; all state updates on rising edge
- RST  in  1  reset, asynchronous, active-high
- A_VALID  in  1  requester A has a write pending
- A_RD  in  AW  requester A destination index
- A_DATA  in  DW  requester A write data
- A_READY  out  1  requester A transfer accepted this cycle (combinational)
- B_VALID  in  1  requester B has a write pending
- B_RD  in  AW  requester B destination index
- B_DATA  in  DW  requester B write data
- B_READY  out  1  requester B transfer accepted this cycle (combinational)
- WR  out  1  register file write enable (registered)
- RD  out  AW  register file write index (registered)
- DIN  out  DW  register file write data (registered)
- BUSY  out  1  high while init zero-fill in progress

## Operation
- **States:** INIT, RUN. Reset forces INIT with init counter CNT=1 and last-grant pointer LAST=B.
- **INIT:** each rising edge registers WR=1, RD=CNT, DIN=0, then increments CNT. On the edge that issues CNT=NREG-1, state moves to RUN. x0 is never written. A_READY=B_READY=0 throughout; requester VALIDs are ignored.
- **RUN arbitration** (combinational from current VALIDs and LAST):
  - Only A valid: grant A.
  - Only B valid: grant B.
  - Both valid: grant the requester not equal to LAST (round-robin).
  - Neither valid: no grant.
- **READY:** READY of the granted requester is 1 and the other is 0. A transfer occurs when VALID && READY. At most one transfer per cycle.
- **On transfer:**
  - Next edge registers RD=granted index and DIN=granted data, and sets LAST=granted requester.
  - WR is registered as 1 only if the index ≠ 0. A write to x0 completes the handshake but is dropped (WR=0).
- **Idle:** with no transfer in RUN, the next edge registers WR=0. RD/DIN hold their previous values.
- **Requester obligations:** VALID, RD and DATA must stay stable until READY is seen. This is a requester-side rule and is not checked by the block.
- **Same destination:** if A and B target the same register, the grants are serialised in round-robin order, and the later grant's data is what ends up in the file.
- **BUSY** = (state == INIT).

## Timing
- **Reset values (asserted asynchronously):** WR=0, RD=0, DIN=0, BUSY=1, A_READY=0, B_READY=0, CNT=1, LAST=B.
- **Init:**
  - Edges 1–31 after RST deasserts issue writes to x1..x31. The 31 cycles follow from NREG=32.
  - BUSY falls after edge 31. The first READY can assert in the cycle following edge 31.
- **Latency:** a transfer in cycle n appears on WR/RD/DIN in cycle n+1, so the file is written at edge n+1. Zero-wait throughput: one write per cycle.
- **Fairness:** with both requesters continuously valid, grants alternate A, B, A, B…, starting with A after reset.
- **Reset mid-operation** (INIT or RUN): all state returns to reset values immediately. A pending output write is cancelled (WR=0). The zero-fill restarts at x1. An in-flight requester transfer is lost.

## Test plan
- **Reset/init:** pulse RST, hold VALIDs high.
  - Required: WR=1 with RD=1..31 and DIN=0 on consecutive edges.
  - Required: BUSY=1 and READY=0 throughout; BUSY=0 after the 31st edge.
- **Single requester:** A_VALID=1, A_RD=5, A_DATA=0xDEADBEEF for one cycle.
  - Required: A_READY=1 that cycle.
  - Required: next cycle WR=1, RD=5, DIN=0xDEADBEEF; the cycle after, WR=0.
- **Contention:** A and B continuously valid with distinct indices (A→3, B→4) for 4 cycles.
  - Required: grant order A, B, A, B; exactly one READY per cycle; WR=1 on every following cycle.
- **x0 drop:** B_VALID=1, B_RD=0, B_DATA=0x1234.
  - Required: B_READY=1 that cycle, then WR=0 on the next cycle.
- **Same destination:** A (rd=7, 0x1) and B (rd=7, 0x2) both valid after an idle period.
  - Required: writes RD=7/0x1, then RD=7/0x2; a read of x7 through the file returns 0x2.
- **Mid-run reset:** assert RST in the same cycle as a granted A transfer.
  - Required: WR=0 immediately, READY=0, BUSY=1.
  - Required: the zero-fill restarts with RD=1 on the first edge after deassertion.
